jk_cmd_sequencer: RTL and testbench

JK_CMD_SEQUENCER -- requirements
Module: jk_cmd_sequencer

---
 rtl/jk_cmd_sequencer.sv | 134 +++++++++++++
 tb/tb_jk_cmd_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: queues {op, len} commands in a small FIFO and replays each one as a
// registered J/K drive held for len+1 cycles. It also tracks the downstream flip-flop's
// expected Q.
module jk_cmd_sequencer #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [1:0]             cmd_op,
   input  logic [3:0]             cmd_len,
   output logic                   J,
   output logic                   K,
   output logic                   busy,
   output logic                   q_model,
   output logic [$clog2(DEPTH):0] fifo_count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam logic [PtrW:0] Full = (PtrW + 1)'(DEPTH);

   typedef enum logic {StIdle, StApply} state_e;

   state_e            state_q, state_d;
   logic [3:0]        rem_q, rem_d;
   logic              j_q, j_d, k_q, k_d, busy_q, busy_d, q_q, q_d;
   logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]     count_q, count_d;
   logic [5:0]        mem_q [DEPTH];
   logic [5:0]        head;
   logic              push, pop;

   // Reset forces cmd_ready low, so nothing is written to the FIFO while reset is asserted.
   assign cmd_ready = (count_q < Full) & reset;
   assign push      = cmd_valid & cmd_ready;
   assign head      = mem_q[rd_ptr_q];

   // FIFO storage: no reset needed, occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_len};
   end

   // Next state and J/K drive: pop the head whenever idle or the current command ends.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      j_d     = j_q;
      k_d     = k_q;
      busy_d  = busy_q;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            j_d    = 1'b0;
            k_d    = 1'b0;
            busy_d = 1'b0;
            pop    = (count_q != '0);
         end
         StApply: begin
            if (rem_q != 4'd0) begin
               rem_d = rem_q - 4'd1;
            end else if (count_q != '0) begin
               pop = 1'b1;
            end else begin
               state_d = StIdle;
               j_d     = 1'b0;
               k_d     = 1'b0;
               busy_d  = 1'b0;
            end
         end
      endcase
      if (pop) begin
         state_d = StApply;
         j_d     = head[5];
         k_d     = head[4];
         rem_d   = head[3:0];
         busy_d  = 1'b1;
      end
   end

   // Occupancy: a simultaneous push and pop leaves the count unchanged.
   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (!push && pop) begin
         count_d = count_q - 1'b1;
      end
   end

   // Expected downstream Q, following the JK characteristic on the currently driven J/K.
   always_comb begin
      q_d = q_q;
      case ({j_q, k_q})
         2'b10:   q_d = 1'b1;
         2'b01:   q_d = 1'b0;
         2'b11:   q_d = ~q_q;
         default: q_d = q_q;
      endcase
   end

   // State register with synchronous active-low reset; reset also discards queued commands.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= StIdle;
         rem_q    <= 4'd0;
         j_q      <= 1'b0;
         k_q      <= 1'b0;
         busy_q   <= 1'b0;
         q_q      <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         j_q     <= j_d;
         k_q     <= k_d;
         busy_q  <= busy_d;
         q_q     <= q_d;
         count_q <= count_d;
         // Pointers wrap naturally because DEPTH is a power of two.
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   assign J          = j_q;
   assign K          = k_q;
   assign busy       = busy_q;
   assign q_model    = q_q;
   assign fifo_count = count_q;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Bench for jk_cmd_sequencer. Accepted commands go into a scoreboard queue, each one
// tagged with its accept edge and its cycle budget. A negedge monitor consumes that queue
// one cycle at a time and checks every output.
module tb_jk_cmd_sequencer;

   localparam int unsigned DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset, cmd_valid, cmd_ready, J, K, busy, q_model;
   logic [1:0] cmd_op;
   logic [3:0] cmd_len;
   logic [2:0] fifo_count;

   always #5 clk = ~clk;

   jk_cmd_sequencer #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_len    (cmd_len),
      .J          (J),
      .K          (K),
      .busy       (busy),
      .q_model    (q_model),
      .fifo_count (fifo_count)
   );

   typedef struct {
      logic [1:0] op;
      int         cyc;
      int         acc;
   } cmd_t;

   cmd_t sb[$];
   int   edge_n    = 0;
   int   model_cnt = 0;
   int   n_checks  = 0;
   int   n_fail    = 0;
   int   dut_acc   = 0;
   bit   started   = 0;
   bit   rst_edge  = 0;
   logic qm = 1'b0, prev_j = 1'b0, prev_k = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   function automatic logic jk_next(input logic q, input logic j, input logic k);
      if (j && k) return ~q;
      if (j) return 1'b1;
      if (k) return 1'b0;
      return q;
   endfunction

   // Scoreboard input: record every command the model says is accepted at this edge.
   always @(posedge clk) begin
      cmd_t c;
      edge_n++;
      started = 1;
      if (!reset) begin
         sb.delete();
         rst_edge = 1;
      end else begin
         rst_edge = 0;
         if (cmd_valid && model_cnt < DEPTH) begin
            c.op  = cmd_op;
            c.cyc = int'(cmd_len) + 1;
            c.acc = edge_n;
            sb.push_back(c);
         end
         if (cmd_valid && cmd_ready) dut_acc++;
      end
   end

   // Monitor: one cycle of expected work per edge, starting no earlier than the edge after accept.
   always @(negedge clk) begin
      logic exp_j, exp_k, exp_busy;
      if (started) begin
         exp_j    = 1'b0;
         exp_k    = 1'b0;
         exp_busy = 1'b0;
         if (rst_edge) qm = 1'b0;
         else          qm = jk_next(qm, prev_j, prev_k);
         if (sb.size() > 0 && sb[0].acc < edge_n) begin
            exp_busy  = 1'b1;
            exp_j     = sb[0].op[1];
            exp_k     = sb[0].op[0];
            model_cnt = sb.size() - 1;
            sb[0].cyc = sb[0].cyc - 1;
            if (sb[0].cyc == 0) void'(sb.pop_front());
         end else begin
            model_cnt = sb.size();
         end
         check("J", J, exp_j);
         check("K", K, exp_k);
         check("busy", busy, exp_busy);
         check("fifo_count", fifo_count, model_cnt);
         check("q_model", q_model, qm);
         check("cmd_ready", cmd_ready, (reset && model_cnt < DEPTH));
         prev_j = exp_j;
         prev_k = exp_k;
      end
   end

   task automatic drive(input logic rst, input logic v, input logic [1:0] op,
                        input logic [3:0] len);
      @(posedge clk);
      #2;
      reset     = rst;
      cmd_valid = v;
      cmd_op    = op;
      cmd_len   = len;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b1, 1'b0, 2'b00, 4'd0);
   endtask

   initial begin
      reset     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_len   = 4'd0;
      // Offer a command while in reset: it must be refused.
      drive(1'b0, 1'b1, 2'b10, 4'd1);
      drive(1'b0, 1'b1, 2'b11, 4'd1);
      idle(2);

      // Single set, three cycles.
      drive(1'b1, 1'b1, 2'b10, 4'd2);
      idle(6);

      // Back-to-back set / clear / toggle.
      drive(1'b1, 1'b1, 2'b10, 4'd0);
      drive(1'b1, 1'b1, 2'b01, 4'd1);
      drive(1'b1, 1'b1, 2'b11, 4'd3);
      idle(10);

      // Fill the FIFO: exactly five accepts expected.
      dut_acc = 0;
      repeat (8) drive(1'b1, 1'b1, 2'b11, 4'd15);
      idle(1);
      check("full_accepts", dut_acc, 5);
      idle(90);

      // Push while a pop happens with two queued.
      drive(1'b1, 1'b1, 2'b10, 4'd1);
      drive(1'b1, 1'b1, 2'b01, 4'd0);
      drive(1'b1, 1'b1, 2'b11, 4'd0);
      drive(1'b1, 1'b1, 2'b10, 4'd2);
      idle(12);

      // Reset during the second cycle of a long set with work queued.
      drive(1'b1, 1'b1, 2'b10, 4'd5);
      drive(1'b1, 1'b1, 2'b01, 4'd1);
      drive(1'b1, 1'b1, 2'b11, 4'd2);
      drive(1'b0, 1'b1, 2'b00, 4'd3);
      drive(1'b0, 1'b1, 2'b10, 4'd3);
      idle(4);

      // Hold command then a one-cycle set.
      drive(1'b1, 1'b1, 2'b00, 4'd3);
      drive(1'b1, 1'b1, 2'b10, 4'd0);
      idle(8);

      // Random traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         logic       r, v;
         logic [1:0] op;
         logic [3:0] len;
         r   = ($urandom_range(0, 63) != 0);
         v   = ($urandom_range(0, 2) != 0);
         op  = 2'($urandom_range(0, 3));
         len = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                           : 4'($urandom_range(0, 3));
         drive(r, v, op, len);
      end
      idle(100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
